// File: rtl/prog2_pkg.sv
// Shared types and constants for the prog2 fixed-point divide engine.
// Operand layout: dividend bytes at 0/1, divisor at 2.
package prog2_pkg;

    typedef enum logic [2:0] {
        ARMED,
        LOAD,
        DIVIDE,
        STORE,
        DONE
    } state_t;

    localparam int ADDR_D_HI    = 0;
    localparam int ADDR_D_LO    = 1;
    localparam int ADDR_V       = 2;
    localparam int RES_ADDR_DEF = 4;

    localparam int D_W      = 16;
    localparam int V_W      = 8;
    localparam int Q_W      = 24;
    localparam int DIV_ITER = 24;
    localparam int CNT_W    = 5;

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift in a numerator bit,
// trial-subtract the divisor, keep the difference unless it borrows.
module restoring_div_step
    import prog2_pkg::*;
(
    input  logic [V_W:0]   rem_in,
    input  logic           num_bit,
    input  logic [V_W-1:0] divisor,
    output logic [V_W:0]   rem_out,
    output logic           q_bit
);

    logic [V_W+1:0] shifted;
    logic [V_W+1:0] trial;

    // rem_in < divisor, so shifted never reaches bit V_W+1 and
    // the top bit of trial is a clean borrow flag.
    always_comb begin
        shifted = {rem_in, num_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[V_W+1];
        rem_out = q_bit ? trial[V_W:0] : shifted[V_W:0];
    end

endmodule

// File: rtl/prog2_div_engine.sv
// Computes floor({D,8'h00}/V) from data memory and stores the
// 24-bit quotient MSB-first at RES_ADDR; V==0 saturates to all ones.
module prog2_div_engine
    import prog2_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RES_ADDR = RES_ADDR_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    state_t         state;
    logic [D_W-1:0] dividend;
    logic [V_W-1:0] divisor;
    logic [Q_W-1:0] quot;
    logic [V_W:0]   rem;
    logic [CNT_W-1:0] cnt;

    logic [V_W:0]   rem_nxt;
    logic           q_bit;
    logic [Q_W-1:0] quot_nxt;

    restoring_div_step u_step (
        .rem_in  (rem),
        .num_bit (quot[Q_W-1]),
        .divisor (divisor),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // quot doubles as numerator shifter: bits leave at the top,
    // quotient bits enter at the bottom.
    assign quot_nxt = {quot[Q_W-2:0], q_bit};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ARMED;
            Ack         <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            dividend    <= '0;
            divisor     <= '0;
            quot        <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                ARMED: begin
                    if (!Start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        mem_addr <= ADDR_W'(ADDR_D_HI);
                    end
                end
                LOAD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(0)) begin
                        dividend[D_W-1:8] <= mem_rd_data;
                        mem_addr          <= ADDR_W'(ADDR_D_LO);
                    end else if (cnt == CNT_W'(1)) begin
                        dividend[7:0] <= mem_rd_data;
                        mem_addr      <= ADDR_W'(ADDR_V);
                    end else begin
                        divisor <= mem_rd_data;
                        rem     <= '0;
                        cnt     <= '0;
                        if (mem_rd_data == 8'h00) begin
                            quot        <= '1;
                            state       <= STORE;
                            mem_wr_en   <= 1'b1;
                            mem_addr    <= ADDR_W'(RES_ADDR);
                            mem_wr_data <= 8'hFF;
                        end else begin
                            quot     <= {dividend, 8'h00};
                            state    <= DIVIDE;
                            mem_addr <= ADDR_W'(ADDR_D_HI);
                        end
                    end
                end
                DIVIDE: begin
                    quot <= quot_nxt;
                    rem  <= rem_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIV_ITER - 1)) begin
                        cnt         <= '0;
                        state       <= STORE;
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= ADDR_W'(RES_ADDR);
                        mem_wr_data <= quot_nxt[Q_W-1:16];
                    end
                end
                STORE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(0)) begin
                        mem_addr    <= ADDR_W'(RES_ADDR + 1);
                        mem_wr_data <= quot[15:8];
                    end else if (cnt == CNT_W'(1)) begin
                        mem_addr    <= ADDR_W'(RES_ADDR + 2);
                        mem_wr_data <= quot[7:0];
                    end else begin
                        cnt         <= '0;
                        state       <= DONE;
                        Ack         <= 1'b1;
                        mem_wr_en   <= 1'b0;
                        mem_addr    <= '0;
                        mem_wr_data <= '0;
                    end
                end
                DONE: begin
                    if (Start) begin
                        state <= ARMED;
                        Ack   <= 1'b0;
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

endmodule

// File: doc/prog2_div_engine.md
PROG2_DIV_ENGINE -- requirements
Module: prog2_div_engine

Interface
REQ-001 Parameter: ADDR_W, default 8, data-memory address width.
REQ-002 Parameter: RES_ADDR, default 4, byte address of result MSB.
REQ-003 Clk  input  1  sole clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  launch request from initiator; program runs after Start falls.
REQ-006 Ack  output  1  registered "run complete" flag.
REQ-007 mem_addr  output  ADDR_W  data-memory byte address; read data is combinational from this address.
REQ-008 mem_rd_data  input  8  data-memory read byte for mem_addr, same cycle.
REQ-009 mem_wr_en  output  1  write strobe; the memory writes mem_wr_data at mem_addr on the rising edge.
REQ-010 mem_wr_data  output  8  write byte.

Function
REQ-011 The block SHALL compute Q = floor({D,8'h00} / V), 24 bits, no rounding, where D = {mem[0],mem[1]} (16-bit dividend) and V = mem[2] (8-bit divisor).
REQ-012 If V == 0, the block SHALL produce Q = 24'hFFFFFF and skip DIVIDE.
REQ-013 Q SHALL be written MSB-first: mem[RES_ADDR] = Q[23:16], mem[RES_ADDR+1] = Q[15:8], mem[RES_ADDR+2] = Q[7:0].
REQ-014 States: ARMED, LOAD, DIVIDE, STORE, DONE.
REQ-015 ARMED: hold while Start==1; go to LOAD on the first edge that samples Start==0.
REQ-016 LOAD: 3 cycles, mem_addr = 0, 1, 2 in order, capturing mem_rd_data each cycle; then DIVIDE, or STORE if V==0.
REQ-017 DIVIDE: restoring division, exactly 24 cycles, one quotient bit per cycle MSB-first; 9-bit partial remainder; trial subtract of V; restore on borrow.
REQ-018 STORE: 3 cycles, mem_wr_en=1, addresses RES_ADDR..RES_ADDR+2 with the bytes of REQ-013; then DONE.
REQ-019 mem_wr_en SHALL be 0 in every state except STORE.
REQ-020 DONE: Ack=1; hold until Start==1, then go to ARMED with Ack=0 on that edge.
REQ-021 Latency: Ack SHALL rise on the 31st rising edge after the first edge sampling Start==0 in ARMED (1+3+24+3); for V==0, on the 7th.
REQ-022 Start changes during LOAD/DIVIDE/STORE SHALL be ignored.
REQ-023 mem_addr SHALL be 0 in ARMED and DONE; mem_wr_data SHALL be 0 outside STORE.

Reset
REQ-024 Reset SHALL immediately force state ARMED, Ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and clear the operand, quotient, remainder and iteration-counter registers.
REQ-025 Reset during any state, including mid-DIVIDE or mid-STORE, SHALL abort the run with no further writes; the next run after release SHALL follow REQ-015.
REQ-026 Start==1 while Reset is high, then Start low before Reset release, SHALL begin the run on the first edge after release.

Structure
REQ-027 Package prog2_pkg SHALL hold the state enum, the operand addresses (0, 1, 2), the default RES_ADDR, the widths (16/8/24), and DIV_ITER=24.
REQ-028 One sub-module, restoring_div_step, SHALL be provided: combinational; takes the 9-bit remainder, the incoming numerator bit and the 8-bit divisor; returns the next remainder and the quotient bit.
REQ-029 The implementation SHALL use a 5-bit iteration counter; no other counters.

Verification
REQ-030 D=16'h0003, V=8'hFF -> Ack after 31 edges; mem[4..6] = 00,00,03.
REQ-031 D=16'h1234, V=8'h07 -> mem[4..6] = 02,9A,49.
REQ-032 D=16'hFFFF, V=8'h01 -> mem[4..6] = FF,FF,00; D=16'h0100, V=8'h02 -> 00,80,00.
REQ-033 V=8'h00, D=16'h5555 -> Ack after 7 edges; mem[4..6] = FF,FF,FF.
REQ-034 Reset asserted at DIVIDE cycle 10 -> Ack=0, mem_wr_en never high, mem[4..6] unchanged. Relaunch with D=3, V=FF -> result 000003.
REQ-035 Back-to-back runs: after Ack, raise Start -> Ack falls on that edge. Drop Start with new operands D=16'h0100, V=8'h02 -> second result 00,80,00.
